button_event_scheduler: RTL and testbench

- Front-end controller for the board's push buttons.
- Synchronises NUM_BTN raw button inputs and latches their press events.
- Arbitrates round-robin, so only one press is debounced at a time through a single shared lockout timer.
- Emits one-cycle event pulses tagged with the button index; the game/UI FSM consumes them in place of per-button debouncers.

---
 rtl/btn_sched_pkg.sv | 15 +
 rtl/rr_picker.sv | 25 ++
 rtl/button_event_scheduler.sv | 119 +++++++++++
 tb/tb_button_event_scheduler.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/btn_sched_pkg.sv
// Shared types and defaults for the push-button event scheduler.
// The FSM state type is exported so checkers can decode the scheduler phase.
package btn_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    LOCKOUT = 2'd2
  } sched_state_t;

  // 0.5 s at 50 MHz.
  localparam int LOCKOUT_CYCLES_DEFAULT = 25000000;
  localparam int TIMER_W_DEFAULT        = 25;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request strictly after 'last',
// scanning upward with wrap-around.
module rr_picker #(
  parameter int NUM_BTN = 4,
  parameter int ID_W    = $clog2(NUM_BTN)
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  // Scan from the farthest offset down so the nearest set bit is assigned last.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      if (req[(int'(last) + k) % NUM_BTN]) begin
        any    = 1'b1;
        winner = ID_W'((int'(last) + k) % NUM_BTN);
      end
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Synchronises raw buttons, latches press events and serves them one at a time
// through a shared lockout timer, emitting one-cycle tagged event pulses.
module button_event_scheduler
  import btn_sched_pkg::*;
#(
  parameter int NUM_BTN        = 4,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEFAULT,
  parameter int TIMER_W        = TIMER_W_DEFAULT,
  parameter int ID_W           = $clog2(NUM_BTN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn,
  output logic               event_valid,
  output logic [ID_W-1:0]    event_id,
  output logic               busy,
  output logic [NUM_BTN-1:0] pending,
  output logic               drop
);

  // Handshake: event_valid is a one-cycle pulse with no back-pressure; the
  // consumer must take event_id in that cycle. drop is an equally short pulse.

  logic [NUM_BTN-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_BTN-1:0] rise;
  logic [NUM_BTN-1:0] pending_q, pending_d;
  logic [NUM_BTN-1:0] set_mask, grant_mask;
  logic               drop_q, drop_d;
  sched_state_t       state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [ID_W-1:0]    cur_id_q, cur_id_d;
  logic [ID_W-1:0]    rr_last_q, rr_last_d;
  logic               pick_any;
  logic [ID_W-1:0]    pick_winner;

  assign rise = sync2_q & ~prev_q;

  rr_picker #(
    .NUM_BTN (NUM_BTN),
    .ID_W    (ID_W)
  ) u_rr_picker (
    .req    (pending_q),
    .last   (rr_last_q),
    .any    (pick_any),
    .winner (pick_winner)
  );

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    cur_id_d   = cur_id_q;
    rr_last_d  = rr_last_q;
    grant_mask = '0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d                 = GRANT;
          cur_id_d                = pick_winner;
          rr_last_d               = pick_winner;
          grant_mask[pick_winner] = 1'b1;
        end
      end
      GRANT: begin
        timer_d = TIMER_W'(LOCKOUT_CYCLES - 1);
        state_d = LOCKOUT;
      end
      LOCKOUT: begin
        // Holding the served button keeps us here: no auto-repeat.
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else if (!sync2_q[cur_id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bounce on the button currently being served must not re-queue it.
  always_comb begin
    set_mask = rise;
    if (state_q != IDLE) begin
      set_mask[cur_id_q] = 1'b0;
    end
    pending_d = (pending_q | set_mask) & ~grant_mask;
    drop_d    = |(set_mask & pending_q & ~grant_mask);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      drop_q    <= 1'b0;
      state_q   <= IDLE;
      timer_q   <= '0;
      cur_id_q  <= '0;
      rr_last_q <= ID_W'(NUM_BTN - 1);
    end else begin
      sync1_q   <= btn;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      cur_id_q  <= cur_id_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign event_valid = (state_q == GRANT);
  assign event_id    = cur_id_q;
  assign busy        = (state_q != IDLE);
  assign pending     = pending_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler: expected event ids are queued by
// the stimulus and popped by an independent monitor on every event pulse.
module tb_button_event_scheduler;

  localparam int NUM_BTN = 4;
  localparam int LOCK    = 8;
  localparam int TIMER_W = 8;
  localparam int ID_W    = 2;

  logic               clk;
  logic               rst_n;
  logic [NUM_BTN-1:0] btn;
  logic               event_valid;
  logic [ID_W-1:0]    event_id;
  logic               busy;
  logic [NUM_BTN-1:0] pending;
  logic               drop;

  logic [ID_W-1:0] exp_q[$];
  int checks;
  int errors;
  int cyc;
  int last_ev;
  int drop_cnt;
  int drop_base;

  button_event_scheduler #(
    .NUM_BTN        (NUM_BTN),
    .LOCKOUT_CYCLES (LOCK),
    .TIMER_W        (TIMER_W),
    .ID_W           (ID_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .event_valid (event_valid),
    .event_id    (event_id),
    .busy        (busy),
    .pending     (pending),
    .drop        (drop)
  );

  // Clock and reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      last_ev = -1;
    end else begin
      if (drop) drop_cnt++;
      if (event_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got id %0d expected none", event_id);
        end else begin
          check("event_id", 32'(event_id), 32'(exp_q.pop_front()));
        end
        if (last_ev >= 0) check("event_spacing_ok", 32'((cyc - last_ev) >= LOCK + 2), 32'd1);
        last_ev = cyc;
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    tick(4);
    n = 0;
    while ((busy || pending != '0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_within_budget", 32'(n < budget), 32'd1);
    tick(2);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    cyc      = 0;
    last_ev  = -1;
    drop_cnt = 0;
    rst_n    = 1'b0;
    btn      = 4'b1111;

    // Reset with all buttons held
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_event_valid", 32'(event_valid), 32'd0);
    check("rst_event_id", 32'(event_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    @(posedge clk); @(negedge clk);
    check("post_rst_pending_r1", 32'(pending), 32'd0);
    check("post_rst_busy_r1", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    check("post_rst_pending_r2", 32'(pending), 32'd0);
    @(posedge clk); @(negedge clk);
    check("post_rst_pending_r3", 32'(pending), 32'hF);
    tick(3);
    btn = 4'b0000;
    wait_idle(200);

    // Simultaneous presses, twice, with rr_last = 3 each time
    for (int b = 0; b < 2; b++) begin
      exp_q.push_back(2'd0);
      exp_q.push_back(2'd1);
      exp_q.push_back(2'd3);
      btn = 4'b1011;
      tick(3);
      btn = 4'b0000;
      wait_idle(200);
    end

    // Single press latency
    exp_q.push_back(2'd2);
    btn = 4'b0100;
    @(posedge clk);
    @(posedge clk); @(negedge clk);
    check("single_pending_e1", 32'(pending), 32'd0);
    @(posedge clk); @(negedge clk);
    check("single_pending_e2", 32'(pending), 32'h4);
    check("single_busy_e2", 32'(busy), 32'd0);
    @(posedge clk); @(negedge clk);
    check("single_event_valid_e3", 32'(event_valid), 32'd1);
    check("single_busy_e3", 32'(busy), 32'd1);
    check("single_pending_e3", 32'(pending), 32'd0);
    btn = 4'b0000;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("single_busy_e11", 32'(busy), 32'd1);
    @(posedge clk); @(negedge clk);
    check("single_busy_e12", 32'(busy), 32'd0);
    wait_idle(100);

    // Bounce then long hold on button 1
    drop_base = drop_cnt;
    exp_q.push_back(2'd1);
    tick(1);
    btn = 4'b0010; tick(2);
    btn = 4'b0000; tick(2);
    btn = 4'b0010; tick(2);
    tick(20);
    check("bounce_hold_busy", 32'(busy), 32'd1);
    btn = 4'b0000;
    wait_idle(100);
    check("bounce_no_drop", 32'(drop_cnt - drop_base), 32'd0);

    // Drop: button 3 pressed twice while already pending
    drop_base = drop_cnt;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd3);
    btn = 4'b0001; tick(3);
    btn = 4'b1000; tick(2);
    btn = 4'b0000; tick(2);
    btn = 4'b1000; tick(2);
    btn = 4'b0000;
    wait_idle(200);
    check("drop_count", 32'(drop_cnt - drop_base), 32'd1);

    // Reset during lockout with button 2 pending
    exp_q.push_back(2'd0);
    btn = 4'b0001; tick(3);
    btn = 4'b0100; tick(2);
    btn = 4'b0000; tick(2);
    @(negedge clk);
    check("midrst_pending_before", 32'(pending), 32'h4);
    check("midrst_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_pending_async", 32'(pending), 32'd0);
    check("midrst_busy_async", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick(30);
    check("midrst_pending_after", 32'(pending), 32'd0);
    check("midrst_busy_after", 32'(busy), 32'd0);

    // Final report
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
